// File: rtl/dm_cache_responder_if.sv
// CPU request/ready handshake and backing-memory bus of the direct-mapped cache.
// The bidirectional CPU data bus is a plain port on the cache itself.
interface dm_cache_responder_if;
    logic        readM;
    logic        writeM;
    logic [15:0] address;
    logic        ready;
    logic        mem_readM;
    logic        mem_writeM;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] access_count;
    logic [15:0] hit_count;

    // Cache side
    modport slave (
        input  readM, writeM, address, mem_rdata, mem_ack,
        output ready, mem_readM, mem_writeM, mem_address, mem_wdata,
               access_count, hit_count
    );

    // CPU / memory-model side
    modport master (
        output readM, writeM, address, mem_rdata, mem_ack,
        input  ready, mem_readM, mem_writeM, mem_address, mem_wdata,
               access_count, hit_count
    );
endinterface

// File: rtl/dm_cache_responder.sv
// Direct-mapped, write-through, no-write-allocate cache responder.
// 2^INDEX_BITS lines of four 16-bit words; whole-line fills, single-word
// write-through, one-cycle ready pulse back to the CPU.
module dm_cache_responder #(
    parameter int INDEX_BITS = 2
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    inout  wire  [15:0]          data,
    dm_cache_responder_if.slave  bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 14 - INDEX_BITS;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_FILL, S_WRITE, S_RESP} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [15:0]            r_addr;
    logic [15:0]            r_wdata;
    logic                   r_is_write;
    logic                   r_hit;
    logic [LINES-1:0]       r_valid;
    logic [TAG_W-1:0]       r_tag  [LINES];
    logic [3:0][15:0]       r_line [LINES];
    logic [15:0]            r_access;
    logic [15:0]            r_hits;

    logic [1:0]             w_off;
    logic [INDEX_BITS-1:0]  w_idx;
    logic [TAG_W-1:0]       w_tag;
    logic                   w_hit;
    logic [15:0]            w_rd_word;
    logic                   w_ready;
    logic                   w_mem_rd;
    logic                   w_mem_wr;
    logic [15:0]            w_mem_addr;
    logic [15:0]            w_mem_wdata;
    logic                   w_fill_done;
    logic                   w_write_done;

    // All lookups work on the address latched in IDLE, never the live bus.
    assign w_off        = r_addr[1:0];
    assign w_idx        = r_addr[INDEX_BITS+1:2];
    assign w_tag        = r_addr[15:INDEX_BITS+2];
    assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_rd_word    = r_line[w_idx][w_off];
    assign w_fill_done  = (r_state == S_FILL)  && bus.mem_ack;
    assign w_write_done = (r_state == S_WRITE) && bus.mem_ack;

    // State register; reset aborts any fill or write-through in flight.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next state and all bus outputs decoded from the current state, so a
    // reset clears them immediately without waiting for a clock edge.
    always_comb begin
        w_next      = r_state;
        w_ready     = 1'b0;
        w_mem_rd    = 1'b0;
        w_mem_wr    = 1'b0;
        w_mem_addr  = 16'h0000;
        w_mem_wdata = 16'h0000;
        case (r_state)
            S_IDLE: begin
                if (bus.readM || bus.writeM) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (r_is_write) begin
                    w_next = S_WRITE;
                end else if (w_hit) begin
                    w_ready = 1'b1;
                    w_next  = S_IDLE;
                end else begin
                    w_next = S_FILL;
                end
            end
            S_FILL: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = {r_addr[15:2], 2'b00};
                if (bus.mem_ack) w_next = S_RESP;
            end
            S_WRITE: begin
                w_mem_wr    = 1'b1;
                w_mem_addr  = r_addr;
                w_mem_wdata = r_wdata;
                if (bus.mem_ack) w_next = S_RESP;
            end
            S_RESP: begin
                w_ready = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request capture, hit flag for the write path, valid bits and counters.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_is_write <= 1'b0;
            r_hit      <= 1'b0;
            r_valid    <= '0;
            r_access   <= 16'h0000;
            r_hits     <= 16'h0000;
        end else begin
            if (r_state == S_IDLE && (bus.readM || bus.writeM)) begin
                r_addr     <= bus.address;
                r_wdata    <= data;
                r_is_write <= bus.writeM;
            end
            if (r_state == S_LOOKUP) begin
                r_hit    <= w_hit;
                r_access <= r_access + 16'd1;
                if (w_hit) r_hits <= r_hits + 16'd1;
            end
            if (w_fill_done) r_valid[w_idx] <= 1'b1;
        end
    end

    // Line storage: whole-line load on fill, single word on a write hit.
    // A write miss leaves the array untouched (no allocate).
    always_ff @(posedge Clk) begin
        if (w_fill_done) begin
            r_line[w_idx] <= bus.mem_rdata;
            r_tag[w_idx]  <= w_tag;
        end else if (w_write_done && r_hit) begin
            r_line[w_idx][w_off] <= r_wdata;
        end
    end

    assign bus.ready        = w_ready;
    assign bus.mem_readM    = w_mem_rd;
    assign bus.mem_writeM   = w_mem_wr;
    assign bus.mem_address  = w_mem_addr;
    assign bus.mem_wdata    = w_mem_wdata;
    assign bus.access_count = r_access;
    assign bus.hit_count    = r_hits;

    // The CPU bus is only driven while returning read data.
    assign data = (w_ready && !r_is_write) ? w_rd_word : 16'hzzzz;
endmodule

// File: tb/tb_dm_cache_responder.sv
// Directed bench for dm_cache_responder: cold miss, hit, write-through,
// conflict eviction, write miss without allocate, and reset mid-fill.
module tb_dm_cache_responder;
    logic        clk;
    logic        rst_n;
    logic [15:0] drv_data;
    logic        drv_en;
    wire  [15:0] data;
    int          errors;
    int          checks;

    dm_cache_responder_if bus();

    dm_cache_responder #(.INDEX_BITS(2)) dut (
        .Clk     (clk),
        .Reset_N (rst_n),
        .data    (data),
        .bus     (bus)
    );

    assign data = drv_en ? drv_data : 16'hzzzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        bus.readM   = rd;
        bus.writeM  = wr;
        bus.address = a;
        drv_data    = d;
        drv_en      = wr;
    endtask

    task automatic end_req();
        bus.readM  = 1'b0;
        bus.writeM = 1'b0;
        drv_en     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
        checks++; if (bus.mem_readM !== 1'b0 || bus.mem_writeM !== 1'b0) begin errors++; $display("FAIL reset_memreq: got rd=%b wr=%b want 0/0", bus.mem_readM, bus.mem_writeM); end
        checks++; if (bus.mem_address !== 16'h0 || bus.mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_membus: got addr=%h wdata=%h want 0/0", bus.mem_address, bus.mem_wdata); end
        checks++; if (bus.access_count !== 16'h0 || bus.hit_count !== 16'h0) begin errors++; $display("FAIL reset_counts: got %h/%h want 0/0", bus.access_count, bus.hit_count); end
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_cold_miss();
        start_req(1'b1, 1'b0, 16'h0010, 16'h0);
        cycle();  // LOOKUP
        checks++; if (bus.ready !== 1'b0 || bus.mem_readM !== 1'b0) begin errors++; $display("FAIL cold_lookup: got ready=%b memrd=%b want 0/0", bus.ready, bus.mem_readM); end
        cycle();  // FILL
        checks++; if (bus.mem_readM !== 1'b1 || bus.mem_address !== 16'h0010 || bus.mem_writeM !== 1'b0) begin errors++; $display("FAIL cold_fill: got rd=%b addr=%h wr=%b want 1/0010/0", bus.mem_readM, bus.mem_address, bus.mem_writeM); end
        cycle();  // still FILL, no ack yet
        checks++; if (bus.mem_readM !== 1'b1 || bus.ready !== 1'b0) begin errors++; $display("FAIL cold_hold: got rd=%b ready=%b want 1/0", bus.mem_readM, bus.ready); end
        bus.mem_rdata = 64'h4444_3333_2222_1111;
        bus.mem_ack   = 1'b1;
        cycle();  // RESP
        bus.mem_ack = 1'b0;
        checks++; if (bus.ready !== 1'b1 || data !== 16'h1111) begin errors++; $display("FAIL cold_resp: got ready=%b data=%h want 1/1111", bus.ready, data); end
        checks++; if (bus.access_count !== 16'd1 || bus.hit_count !== 16'd0) begin errors++; $display("FAIL cold_counts: got %0d/%0d want 1/0", bus.access_count, bus.hit_count); end
        end_req();
        cycle();  // IDLE
        checks++; if (bus.ready !== 1'b0 || bus.mem_readM !== 1'b0) begin errors++; $display("FAIL cold_idle: got ready=%b rd=%b want 0/0", bus.ready, bus.mem_readM); end
    endtask

    task automatic test_read_hit();
        start_req(1'b1, 1'b0, 16'h0013, 16'h0);
        cycle();  // LOOKUP, hit
        checks++; if (bus.ready !== 1'b1 || data !== 16'h4444 || bus.mem_readM !== 1'b0) begin errors++; $display("FAIL hit_resp: got ready=%b data=%h rd=%b want 1/4444/0", bus.ready, data, bus.mem_readM); end
        end_req();
        cycle();
        checks++; if (bus.access_count !== 16'd2 || bus.hit_count !== 16'd1) begin errors++; $display("FAIL hit_counts: got %0d/%0d want 2/1", bus.access_count, bus.hit_count); end
    endtask

    task automatic test_write_hit();
        start_req(1'b0, 1'b1, 16'h0011, 16'hBEEF);
        cycle();  // LOOKUP
        // Later address/data changes must not leak into the write-through.
        bus.address = 16'hFFFF;
        drv_data    = 16'h0000;
        cycle();  // WRITE
        checks++; if (bus.mem_writeM !== 1'b1 || bus.mem_address !== 16'h0011 || bus.mem_wdata !== 16'hBEEF || bus.mem_readM !== 1'b0) begin errors++; $display("FAIL wr_bus: got wr=%b addr=%h wdata=%h rd=%b want 1/0011/beef/0", bus.mem_writeM, bus.mem_address, bus.mem_wdata, bus.mem_readM); end
        bus.mem_ack = 1'b1;
        cycle();  // RESP
        bus.mem_ack = 1'b0;
        checks++; if (bus.ready !== 1'b1 || bus.mem_writeM !== 1'b0) begin errors++; $display("FAIL wr_resp: got ready=%b wr=%b want 1/0", bus.ready, bus.mem_writeM); end
        end_req();
        cycle();
        checks++; if (bus.access_count !== 16'd3 || bus.hit_count !== 16'd2) begin errors++; $display("FAIL wr_counts: got %0d/%0d want 3/2", bus.access_count, bus.hit_count); end
        start_req(1'b1, 1'b0, 16'h0011, 16'h0);
        cycle();
        checks++; if (bus.ready !== 1'b1 || data !== 16'hBEEF) begin errors++; $display("FAIL wr_readback: got ready=%b data=%h want 1/beef", bus.ready, data); end
        end_req();
        cycle();
    endtask

    task automatic test_conflict();
        start_req(1'b1, 1'b0, 16'h0050, 16'h0);
        cycle();
        cycle();  // FILL
        checks++; if (bus.mem_readM !== 1'b1 || bus.mem_address !== 16'h0050) begin errors++; $display("FAIL evict_fill: got rd=%b addr=%h want 1/0050", bus.mem_readM, bus.mem_address); end
        bus.mem_rdata = 64'h8888_7777_6666_5555;
        bus.mem_ack   = 1'b1;
        cycle();
        bus.mem_ack = 1'b0;
        checks++; if (bus.ready !== 1'b1 || data !== 16'h5555) begin errors++; $display("FAIL evict_resp: got ready=%b data=%h want 1/5555", bus.ready, data); end
        end_req();
        cycle();
        start_req(1'b1, 1'b0, 16'h0010, 16'h0);
        cycle();  // LOOKUP, must miss now
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL evict_miss: got ready=%b want 0", bus.ready); end
        cycle();
        checks++; if (bus.mem_readM !== 1'b1 || bus.mem_address !== 16'h0010) begin errors++; $display("FAIL evict_refill: got rd=%b addr=%h want 1/0010", bus.mem_readM, bus.mem_address); end
        bus.mem_rdata = 64'h4444_3333_2222_1111;
        bus.mem_ack   = 1'b1;
        cycle();
        bus.mem_ack = 1'b0;
        checks++; if (data !== 16'h1111 || bus.access_count !== 16'd6 || bus.hit_count !== 16'd3) begin errors++; $display("FAIL evict_counts: got data=%h %0d/%0d want 1111 6/3", data, bus.access_count, bus.hit_count); end
        end_req();
        cycle();
    endtask

    task automatic test_write_miss();
        // Stray ack while idle must be ignored.
        bus.mem_ack = 1'b1;
        cycle();
        bus.mem_ack = 1'b0;
        checks++; if (bus.ready !== 1'b0 || bus.mem_readM !== 1'b0 || bus.mem_writeM !== 1'b0) begin errors++; $display("FAIL stray_ack: got ready=%b rd=%b wr=%b want 0/0/0", bus.ready, bus.mem_readM, bus.mem_writeM); end
        start_req(1'b0, 1'b1, 16'h0100, 16'h1234);
        cycle();
        cycle();  // WRITE
        checks++; if (bus.mem_writeM !== 1'b1 || bus.mem_address !== 16'h0100 || bus.mem_wdata !== 16'h1234) begin errors++; $display("FAIL wmiss_bus: got wr=%b addr=%h wdata=%h want 1/0100/1234", bus.mem_writeM, bus.mem_address, bus.mem_wdata); end
        bus.mem_ack = 1'b1;
        cycle();
        bus.mem_ack = 1'b0;
        end_req();
        cycle();
        start_req(1'b1, 1'b0, 16'h0100, 16'h0);
        cycle();
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL wmiss_noalloc: got ready=%b want 0", bus.ready); end
        cycle();
        checks++; if (bus.mem_readM !== 1'b1 || bus.mem_address !== 16'h0100) begin errors++; $display("FAIL wmiss_fill: got rd=%b addr=%h want 1/0100", bus.mem_readM, bus.mem_address); end
        bus.mem_rdata = 64'hDDDD_CCCC_BBBB_AAAA;
        bus.mem_ack   = 1'b1;
        cycle();
        bus.mem_ack = 1'b0;
        checks++; if (data !== 16'hAAAA || bus.access_count !== 16'd8 || bus.hit_count !== 16'd3) begin errors++; $display("FAIL wmiss_counts: got data=%h %0d/%0d want aaaa 8/3", data, bus.access_count, bus.hit_count); end
        end_req();
        cycle();
    endtask

    task automatic test_read_and_write();
        // Both strobes high is a write.
        start_req(1'b1, 1'b1, 16'h0104, 16'h5A5A);
        cycle();
        cycle();
        checks++; if (bus.mem_writeM !== 1'b1 || bus.mem_readM !== 1'b0 || bus.mem_wdata !== 16'h5A5A) begin errors++; $display("FAIL both_is_write: got wr=%b rd=%b wdata=%h want 1/0/5a5a", bus.mem_writeM, bus.mem_readM, bus.mem_wdata); end
        bus.mem_ack = 1'b1;
        cycle();
        bus.mem_ack = 1'b0;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL both_ready: got %b want 1", bus.ready); end
        end_req();
        cycle();
    endtask

    task automatic test_reset_mid_fill();
        start_req(1'b1, 1'b0, 16'h0020, 16'h0);
        cycle();
        cycle();  // FILL
        checks++; if (bus.mem_readM !== 1'b1) begin errors++; $display("FAIL rst_prefill: got rd=%b want 1", bus.mem_readM); end
        #2;
        rst_n = 1'b0;
        #1;       // no clock edge in between
        checks++; if (bus.mem_readM !== 1'b0 || bus.ready !== 1'b0 || bus.mem_address !== 16'h0) begin errors++; $display("FAIL rst_async_bus: got rd=%b ready=%b addr=%h want 0/0/0", bus.mem_readM, bus.ready, bus.mem_address); end
        checks++; if (bus.access_count !== 16'h0 || bus.hit_count !== 16'h0) begin errors++; $display("FAIL rst_async_counts: got %0d/%0d want 0/0", bus.access_count, bus.hit_count); end
        end_req();
        bus.mem_rdata = 64'hFFFF_EEEE_9999_0000;
        bus.mem_ack   = 1'b1;
        cycle();
        bus.mem_ack = 1'b0;
        rst_n = 1'b1;
        cycle();
        start_req(1'b1, 1'b0, 16'h0010, 16'h0);
        cycle();
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL rst_line_gone: got ready=%b want 0", bus.ready); end
        cycle();
        checks++; if (bus.mem_readM !== 1'b1 || bus.mem_address !== 16'h0010) begin errors++; $display("FAIL rst_refill: got rd=%b addr=%h want 1/0010", bus.mem_readM, bus.mem_address); end
        bus.mem_rdata = 64'h4444_3333_2222_1111;
        bus.mem_ack   = 1'b1;
        cycle();
        bus.mem_ack = 1'b0;
        checks++; if (data !== 16'h1111 || bus.access_count !== 16'd1 || bus.hit_count !== 16'd0) begin errors++; $display("FAIL rst_after: got data=%h %0d/%0d want 1111 1/0", data, bus.access_count, bus.hit_count); end
        end_req();
        cycle();
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        drv_en        = 1'b0;
        drv_data      = 16'h0;
        bus.readM     = 1'b0;
        bus.writeM    = 1'b0;
        bus.address   = 16'h0;
        bus.mem_rdata = 64'h0;
        bus.mem_ack   = 1'b0;
        test_reset();
        test_cold_miss();
        test_read_hit();
        test_write_hit();
        test_conflict();
        test_write_miss();
        test_read_and_write();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
